// File: rtl/ram_fifo_pkg.sv
// Shared defaults and types for the RAM-backed FIFO controller.
// Widths mirror the existing dual-port ram defaults.
package ram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    typedef logic [DEF_ADDR_WIDTH:0] count_t;

    // The circular pointers rely on natural binary wrap, so depth must be a power of two.
    function automatic bit depth_ok(input int addr_width, input int depth);
        return depth == (1 << addr_width);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream, status and RAM-side signals of the FIFO controller.
// master is the controller's view, slave is the surrounding logic's view.
interface ram_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_din;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_dout;

    modport master (
        input  push, push_data, pop, clr_err, ram_rd_dout,
        output pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, ram_we, ram_wr_addr, ram_wr_din,
               ram_re, ram_rd_addr
    );

    modport slave (
        output push, push_data, pop, clr_err, ram_rd_dout,
        input  pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, ram_we, ram_wr_addr, ram_wr_din,
               ram_re, ram_rd_addr
    );
endinterface

// File: rtl/ram.sv
// Simple dual-port RAM: synchronous write, registered read with one-cycle latency.
// The read register clears on synchronous reset; array contents are not reset.
module ram
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dout
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_din;
    end

    always_ff @(posedge clk) begin
        if (rst)     rd_dout <= '0;
        else if (re) rd_dout <= mem[rd_addr];
    end

endmodule

// File: rtl/ram_fifo.sv
// Complete FIFO: the controller plus the dual-port RAM it drives.
module ram_fifo
    import ram_fifo_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DEF_DATA_WIDTH-1:0] push_data,
    input  logic                      pop,
    input  logic                      clr_err,
    output logic [DEF_DATA_WIDTH-1:0] pop_data,
    output logic                      pop_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output count_t                    count,
    output logic                      overflow,
    output logic                      underflow
);
    ram_fifo_ctrl_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

    assign bus.push      = push;
    assign bus.push_data = push_data;
    assign bus.pop       = pop;
    assign bus.clr_err   = clr_err;
    assign pop_data      = bus.pop_data;
    assign pop_valid     = bus.pop_valid;
    assign full          = bus.full;
    assign empty         = bus.empty;
    assign almost_full   = bus.almost_full;
    assign count         = bus.count;
    assign overflow      = bus.overflow;
    assign underflow     = bus.underflow;

    ram_fifo_ctrl u_ctrl (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.ram_we),
        .wr_addr (bus.ram_wr_addr),
        .wr_din  (bus.ram_wr_din),
        .re      (bus.ram_re),
        .rd_addr (bus.ram_rd_addr),
        .rd_dout (bus.ram_rd_dout)
    );

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM with circular addresses; tracks
// occupancy and sticky error flags and re-times the RAM read latency into pop_valid.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.master bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AFULL = CW'(AFULL_THRESH);

    if (!depth_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_depth
        $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("ram_fifo_ctrl: AFULL_THRESH out of range 1..DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  pop_valid;
    logic                  overflow;
    logic                  underflow;
    logic                  push_acc;
    logic                  pop_acc;

    // Accepts look only at registered flags, so a full FIFO never takes a push
    // even when a pop is accepted in the same cycle (and vice versa when empty).
    always_comb begin
        push_acc  = bus.push & ~full;
        pop_acc   = bus.pop & ~empty;
        count_nxt = count;
        if (push_acc && !pop_acc) begin
            count_nxt = count + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            pop_valid   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
            count       <= count_nxt;
            full        <= (count_nxt == CNT_FULL);
            empty       <= (count_nxt == '0);
            almost_full <= (count_nxt >= CNT_AFULL);
            pop_valid   <= pop_acc;
            // A fresh error event takes priority over a clear in the same cycle.
            if (bus.push && full)       overflow  <= 1'b1;
            else if (bus.clr_err)       overflow  <= 1'b0;
            if (bus.pop && empty)       underflow <= 1'b1;
            else if (bus.clr_err)       underflow <= 1'b0;
        end
    end

    assign bus.ram_we      = push_acc;
    assign bus.ram_wr_addr = wr_ptr;
    assign bus.ram_wr_din  = bus.push_data;
    assign bus.ram_re      = pop_acc;
    assign bus.ram_rd_addr = rd_ptr;
    assign bus.pop_data    = bus.ram_rd_dout;
    assign bus.pop_valid   = pop_valid;
    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = almost_full;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (with a RAM attached) and the ram_fifo top.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

    ram_fifo_ctrl #(
        .ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DATA_WIDTH),
        .DEPTH(DEF_DEPTH), .AFULL_THRESH(12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.ram_we),
        .wr_addr (bus.ram_wr_addr),
        .wr_din  (bus.ram_wr_din),
        .re      (bus.ram_re),
        .rd_addr (bus.ram_rd_addr),
        .rd_dout (bus.ram_rd_dout)
    );

    logic [7:0] t_pop_data;
    logic       t_pop_valid, t_full, t_empty, t_af, t_ovf, t_unf;
    count_t     t_count;

    ram_fifo u_top (
        .clk         (clk),
        .rst         (rst),
        .push        (bus.push),
        .push_data   (bus.push_data),
        .pop         (bus.pop),
        .clr_err     (bus.clr_err),
        .pop_data    (t_pop_data),
        .pop_valid   (t_pop_valid),
        .full        (t_full),
        .empty       (t_empty),
        .almost_full (t_af),
        .count       (t_count),
        .overflow    (t_ovf),
        .underflow   (t_unf)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;

    initial begin
        rst = 1'b1;
        bus.push = 1'b0;
        bus.push_data = '0;
        bus.pop = 1'b0;
        bus.clr_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);

        // fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1;
            bus.push_data = 8'(i);
            #1;
            chk("fill_we", 32'(bus.ram_we), 1);
            chk("fill_wr_addr", 32'(bus.ram_wr_addr), 32'(i));
            tick();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_afull", 32'(bus.almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
            chk("fill_empty", 32'(bus.empty), 0);
            chk("fill_top_count", 32'(t_count), 32'(i + 1));
        end
        bus.push = 1'b0;

        // push while full
        bus.push = 1'b1;
        bus.push_data = 8'hAA;
        #1;
        chk("ovf_we_blocked", 32'(bus.ram_we), 0);
        tick();
        bus.push = 1'b0;
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);
        chk("ovf_full", 32'(bus.full), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 0);

        // drain 16 back-to-back
        bus.pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_rd_addr", 32'(bus.ram_rd_addr), 32'(i));
            tick();
            chk("drain_valid", 32'(bus.pop_valid), 1);
            chk("drain_data", 32'(bus.pop_data), 32'(i));
            chk("drain_count", 32'(bus.count), 32'(15 - i));
            chk("drain_afull", 32'(bus.almost_full), (15 - i >= 12) ? 32'd1 : 32'd0);
            chk("drain_empty", 32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
            chk("drain_top_data", 32'(t_pop_data), 32'(i));
            chk("drain_full", 32'(bus.full), 0);
        end
        bus.pop = 1'b0;
        tick();
        chk("drain_valid_off", 32'(bus.pop_valid), 0);
        chk("drain_still_empty", 32'(bus.empty), 1);

        // push and pop together while empty
        bus.push = 1'b1;
        bus.push_data = 8'h55;
        bus.pop = 1'b1;
        #1;
        chk("pe_re_blocked", 32'(bus.ram_re), 0);
        chk("pe_we", 32'(bus.ram_we), 1);
        tick();
        chk("pe_underflow", 32'(bus.underflow), 1);
        chk("pe_count", 32'(bus.count), 1);
        chk("pe_empty", 32'(bus.empty), 0);
        chk("pe_valid", 32'(bus.pop_valid), 0);
        bus.push = 1'b0;
        #1;
        chk("pe_re", 32'(bus.ram_re), 1);
        tick();
        bus.pop = 1'b0;
        chk("pe_valid2", 32'(bus.pop_valid), 1);
        chk("pe_data", 32'(bus.pop_data), 32'h55);
        chk("pe_count2", 32'(bus.count), 0);
        chk("pe_empty2", 32'(bus.empty), 1);
        chk("pe_unf_sticky", 32'(bus.underflow), 1);
        // set event beats a simultaneous clear
        bus.pop = 1'b1;
        bus.clr_err = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("unf_set_wins", 32'(bus.underflow), 1);
        tick();
        bus.clr_err = 1'b0;
        chk("unf_cleared", 32'(bus.underflow), 0);
        chk("top_unf_cleared", 32'(t_unf), 0);

        // preload 5 words, then 40 cycles of simultaneous push/pop
        q.delete();
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1;
            bus.push_data = 8'(8'h10 + i);
            q.push_back(8'(8'h10 + i));
            tick();
        end
        chk("ss_pre_count", 32'(bus.count), 5);
        for (int k = 0; k < 40; k++) begin
            bus.push = 1'b1;
            bus.pop = 1'b1;
            bus.push_data = 8'(8'h20 + k);
            tick();
            exp_d = q.pop_front();
            q.push_back(8'(8'h20 + k));
            chk("ss_count", 32'(bus.count), 5);
            chk("ss_valid", 32'(bus.pop_valid), 1);
            chk("ss_data", 32'(bus.pop_data), 32'(exp_d));
            chk("ss_top_data", 32'(t_pop_data), 32'(exp_d));
        end
        bus.push = 1'b0;
        bus.pop = 1'b0;
        tick();
        chk("ss_end_count", 32'(bus.count), 5);
        chk("ss_end_valid", 32'(bus.pop_valid), 0);

        // async reset while a pop is in flight
        bus.pop = 1'b1;
        tick();
        chk("ar_pre_valid", 32'(bus.pop_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(bus.count), 0);
        chk("ar_empty", 32'(bus.empty), 1);
        chk("ar_valid", 32'(bus.pop_valid), 0);
        chk("ar_full", 32'(bus.full), 0);
        chk("ar_afull", 32'(bus.almost_full), 0);
        chk("ar_top_count", 32'(t_count), 0);
        bus.pop = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("ar_post_valid", 32'(bus.pop_valid), 0);
        chk("ar_post_count", 32'(bus.count), 0);
        chk("ar_post_empty", 32'(bus.empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the dual-port ram block and drives its write and read interfaces. It turns a push/pop stream interface into RAM write and read strobes with circular addresses. It tracks occupancy, full, empty and almost-full, and error flags. It re-times the RAM's one-cycle read latency into a pop_valid qualifier, so ram plus ram_fifo_ctrl together form a complete FIFO.

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.
- DEPTH, 16, number of entries.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  write request.
- push_data  in  DATA_WIDTH  write data.
- pop  in  1  read request.
- pop_data  out  DATA_WIDTH  read data; direct pass-through of ram_rd_dout.
- pop_valid  out  1  pop_data is valid this cycle.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push arrived while full.
- underflow  out  1  sticky: a pop arrived while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.
- ram_we  out  1  to ram.we.
- ram_wr_addr  out  ADDR_WIDTH  to ram.wr_addr.
- ram_wr_din  out  DATA_WIDTH  to ram.wr_din.
- ram_re  out  1  to ram.re.
- ram_rd_addr  out  ADDR_WIDTH  to ram.rd_addr.
- ram_rd_dout  in  DATA_WIDTH  from ram.rd_dout.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1; full, almost_full, pop_valid, overflow and underflow = 0.
  - Any in-flight read is discarded; pop_valid stays 0 in the first cycle after reset.
- Accept conditions, evaluated against registered flags:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
- RAM drive is combinational from the current state:
  - ram_we = push_acc, ram_wr_addr = wr_ptr, ram_wr_din = push_data.
  - ram_re = pop_acc, ram_rd_addr = rd_ptr.
- Pointers:
  - ADDR_WIDTH bits each, increment by 1 on accept, natural wrap from DEPTH-1 to 0.
- Count:
  - +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither.
  - full, empty and almost_full are registered and derived from the next count value, so they are valid in the same cycle as count.
- Read latency:
  - pop_valid is a register equal to pop_acc delayed by one cycle.
  - pop_data is valid only while pop_valid = 1.
  - Back-to-back pops yield one word per cycle.
- Simultaneous push and pop:
  - When full: the pop is accepted and the push is rejected (full is registered); overflow sets.
  - When empty: the push is accepted and the pop is rejected; underflow sets. The pushed word becomes readable on the next cycle.
  - Otherwise both are accepted and count holds. wr_ptr never equals rd_ptr in this case, so there is no RAM address collision.
- Error flags:
  - overflow sets on push & full; underflow sets on pop & empty.
  - clr_err clears both flags next cycle. A new set event in the same cycle as clr_err wins.
- The RAM's own synchronous reset is tied to the same rst. Data contents after reset are don't-care to this block.

Decomposition:
- Package ram_fifo_pkg holds:
  - default ADDR_WIDTH, DATA_WIDTH and DEPTH (taken from the existing ram defines);
  - a count_t typedef of width ADDR_WIDTH+1;
  - a DEPTH == 2**ADDR_WIDTH elaboration check.
- No sub-module inside the controller.
- A thin top, ram_fifo, instantiates ram_fifo_ctrl plus ram. That top is the verification target alongside the standalone controller.

Test Plan:
1. Reset, then 16 pushes of 0x00..0x0F with no pops -> count = 16, full = 1 after the 16th push, almost_full = 1 from count 12, empty = 0.
2. From full, push 0xAA -> rejected, overflow = 1, count stays 16; then clr_err -> overflow = 0.
3. From full, 16 back-to-back pops -> pop_valid each cycle starting one cycle after the first pop, data 0x00..0x0F in order, empty = 1 after the last pop.
4. From empty, push 0x55 and pop in the same cycle -> only the push is accepted, underflow = 1, count = 1. A pop next cycle returns 0x55 with pop_valid one cycle later.
5. With count = 5, continuous simultaneous push and pop for 40 cycles -> count holds at 5, both pointers wrap at least twice, output sequence exactly matches input order.
6. Assert rst asynchronously mid-stream while a pop is in flight -> all outputs take reset values immediately, and pop_valid = 0 in the next cycle.
